// File: rtl/vga_out_pkg.sv
// rtl/vga_out_pkg.sv - shared widths, polarity constants and dither helper for the VGA output stage
package vga_out_pkg;

    localparam int COL_IN_W  = 6;
    localparam int COL_OUT_W = 5;
    localparam logic [COL_OUT_W-1:0] COL_OUT_MAX = 5'd31;

    localparam logic ACTIVE_LOW  = 1'b0;
    localparam logic ACTIVE_HIGH = 1'b1;

    // Drop the LSB, optionally rounding up by the dither threshold; clamp so 63 never wraps to 0.
    function automatic logic [COL_OUT_W-1:0] dither_chan(
        input logic [COL_IN_W-1:0] c,
        input logic                thr,
        input logic                en
    );
        logic [COL_OUT_W:0] sum;
        sum = {1'b0, c[COL_IN_W-1:1]} + {{COL_OUT_W{1'b0}}, c[0] & thr & en};
        if (sum > {1'b0, COL_OUT_MAX}) begin
            dither_chan = COL_OUT_MAX;
        end else begin
            dither_chan = sum[COL_OUT_W-1:0];
        end
    endfunction

endpackage

// File: rtl/sync_pol_detect.sv
// rtl/sync_pol_detect.sv - measures high/low duration of one sync signal and decides its polarity
module sync_pol_detect
    import vga_out_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int LOCK_COUNT = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic sig,
    input  logic count_en,
    output logic pol,
    output logic stable
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [MW-1:0]    MATCH_MAX = MW'(LOCK_COUNT);

    logic             sig_q, sig_d;
    logic             seen_rise_q, seen_rise_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic             pol_q, pol_d;
    logic [MW-1:0]    match_q, match_d;
    logic             rise, fall, meas;

    // Count phase durations; a measurement needs a full high phase followed by a full low phase.
    always_comb begin
        sig_d       = sig;
        seen_rise_d = seen_rise_q;
        armed_d     = armed_q;
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        pol_d       = pol_q;
        match_d     = match_q;
        meas        = pol_q;
        rise        = sig & ~sig_q;
        fall        = ~sig & sig_q;

        if (count_en) begin
            if (sig) begin
                if (high_cnt_q != CNT_MAX) high_cnt_d = high_cnt_q + CNT_W'(1);
            end else begin
                if (low_cnt_q != CNT_MAX) low_cnt_d = low_cnt_q + CNT_W'(1);
            end
        end

        if (fall && seen_rise_q) armed_d = 1'b1;

        if (rise) begin
            seen_rise_d = 1'b1;
            low_cnt_d   = '0;
            high_cnt_d  = {{(CNT_W-1){1'b0}}, count_en};
            if (armed_q) begin
                if (high_cnt_q < low_cnt_q) begin
                    meas = ACTIVE_HIGH;
                end else if (high_cnt_q > low_cnt_q) begin
                    meas = ACTIVE_LOW;
                end
                pol_d = meas;
                if (meas == pol_q) begin
                    if (match_q != MATCH_MAX) match_d = match_q + MW'(1);
                end else begin
                    match_d = '0;
                end
            end
        end
    end

    // State register; reset forces a fresh complete low/high phase before the next decision.
    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q       <= 1'b0;
            seen_rise_q <= 1'b0;
            armed_q     <= 1'b0;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            pol_q       <= 1'b0;
            match_q     <= '0;
        end else begin
            sig_q       <= sig_d;
            seen_rise_q <= seen_rise_d;
            armed_q     <= armed_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            pol_q       <= pol_d;
            match_q     <= match_d;
        end
    end

    assign pol    = pol_q;
    assign stable = (match_q == MATCH_MAX);

endmodule

// File: rtl/vga_out_stage.sv
// rtl/vga_out_stage.sv - sync polarity normalisation, 6->5 bit ordered dither, blanking and output register
module vga_out_stage
    import vga_out_pkg::*;
#(
    parameter int HCNT_W     = 12,
    parameter int VCNT_W     = 11,
    parameter int LOCK_COUNT = 2
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    input  logic                 pix_ce,
    input  logic [COL_IN_W-1:0]  r_in,
    input  logic [COL_IN_W-1:0]  g_in,
    input  logic [COL_IN_W-1:0]  b_in,
    input  logic                 hs_in,
    input  logic                 vs_in,
    input  logic                 dither_en,
    input  logic                 temporal_en,
    input  logic                 hs_pol_out,
    input  logic                 vs_pol_out,
    output logic [COL_OUT_W-1:0] VGA_R,
    output logic [COL_OUT_W-1:0] VGA_G,
    output logic [COL_OUT_W-1:0] VGA_B,
    output logic                 VGA_HS,
    output logic                 VGA_VS,
    output logic                 hs_pol_det,
    output logic                 vs_pol_det,
    output logic                 locked
);

    logic hs_stable, vs_stable;
    logic hs_in_q, hs_in_d, hs_in_rise;
    logic hs_act, vs_act, hs_act_rise, vs_act_rise, thr, blank;
    logic hs_act_q, hs_act_d, vs_act_q, vs_act_d;
    logic x_ph_q, x_ph_d, y_ph_q, y_ph_d, f_ph_q, f_ph_d;
    logic [COL_OUT_W-1:0] vga_r_q, vga_r_d, vga_g_q, vga_g_d, vga_b_q, vga_b_d;
    logic vga_hs_q, vga_hs_d, vga_vs_q, vga_vs_d, locked_q, locked_d;

    // VS durations are measured in lines, so its counter advances on raw HS rising edges.
    assign hs_in_rise = hs_in & ~hs_in_q;

    sync_pol_detect #(.CNT_W(HCNT_W), .LOCK_COUNT(LOCK_COUNT)) u_hs_det (
        .clk(clk_sys), .reset(reset), .sig(hs_in), .count_en(1'b1),
        .pol(hs_pol_det), .stable(hs_stable)
    );

    sync_pol_detect #(.CNT_W(VCNT_W), .LOCK_COUNT(LOCK_COUNT)) u_vs_det (
        .clk(clk_sys), .reset(reset), .sig(vs_in), .count_en(hs_in_rise),
        .pol(vs_pol_det), .stable(vs_stable)
    );

    // Normalise sync, advance dither phases, and form the next output word.
    always_comb begin
        hs_in_d     = hs_in;
        hs_act      = (hs_pol_det == ACTIVE_HIGH) ? hs_in : ~hs_in;
        vs_act      = (vs_pol_det == ACTIVE_HIGH) ? vs_in : ~vs_in;
        hs_act_d    = hs_act;
        vs_act_d    = vs_act;
        hs_act_rise = hs_act & ~hs_act_q;
        vs_act_rise = vs_act & ~vs_act_q;

        x_ph_d = x_ph_q;
        if (hs_act_rise)  x_ph_d = 1'b0;
        else if (pix_ce)  x_ph_d = ~x_ph_q;

        y_ph_d = y_ph_q;
        if (vs_act_rise)      y_ph_d = 1'b0;
        else if (hs_act_rise) y_ph_d = ~y_ph_q;

        f_ph_d = f_ph_q;
        if (vs_act_rise && temporal_en) f_ph_d = ~f_ph_q;

        thr   = x_ph_q ^ y_ph_q ^ (f_ph_q & temporal_en);
        blank = hs_act | vs_act;

        vga_r_d  = blank ? '0 : dither_chan(r_in, thr, dither_en);
        vga_g_d  = blank ? '0 : dither_chan(g_in, thr, dither_en);
        vga_b_d  = blank ? '0 : dither_chan(b_in, thr, dither_en);
        vga_hs_d = ~(hs_act ^ hs_pol_out);
        vga_vs_d = ~(vs_act ^ vs_pol_out);
        locked_d = hs_stable & vs_stable;
    end

    // Output and phase registers, updated every clk_sys so colour and sync share one cycle of latency.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            hs_in_q  <= 1'b0;
            hs_act_q <= 1'b0;
            vs_act_q <= 1'b0;
            x_ph_q   <= 1'b0;
            y_ph_q   <= 1'b0;
            f_ph_q   <= 1'b0;
            vga_r_q  <= '0;
            vga_g_q  <= '0;
            vga_b_q  <= '0;
            vga_hs_q <= (hs_pol_out == ACTIVE_LOW);
            vga_vs_q <= (vs_pol_out == ACTIVE_LOW);
            locked_q <= 1'b0;
        end else begin
            hs_in_q  <= hs_in_d;
            hs_act_q <= hs_act_d;
            vs_act_q <= vs_act_d;
            x_ph_q   <= x_ph_d;
            y_ph_q   <= y_ph_d;
            f_ph_q   <= f_ph_d;
            vga_r_q  <= vga_r_d;
            vga_g_q  <= vga_g_d;
            vga_b_q  <= vga_b_d;
            vga_hs_q <= vga_hs_d;
            vga_vs_q <= vga_vs_d;
            locked_q <= locked_d;
        end
    end

    assign VGA_R  = vga_r_q;
    assign VGA_G  = vga_g_q;
    assign VGA_B  = vga_b_q;
    assign VGA_HS = vga_hs_q;
    assign VGA_VS = vga_vs_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_vga_out_stage.sv
// tb/tb_vga_out_stage.sv - scoreboard bench for vga_out_stage with scaled-down video timing
module tb_vga_out_stage;

    localparam int L   = 40;
    localparam int HSW = 5;
    localparam int NL  = 12;
    localparam int VSW = 2;

    logic       clk_sys = 1'b0;
    logic       reset, pix_ce, hs_in, vs_in;
    logic       dither_en, temporal_en, hs_pol_out, vs_pol_out;
    logic [5:0] r_in, g_in, b_in;
    logic [4:0] VGA_R, VGA_G, VGA_B;
    logic       VGA_HS, VGA_VS, hs_pol_det, vs_pol_det, locked;

    vga_out_stage dut (
        .clk_sys(clk_sys), .reset(reset), .pix_ce(pix_ce),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_in(hs_in), .vs_in(vs_in),
        .dither_en(dither_en), .temporal_en(temporal_en),
        .hs_pol_out(hs_pol_out), .vs_pol_out(vs_pol_out),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS),
        .hs_pol_det(hs_pol_det), .vs_pol_det(vs_pol_det), .locked(locked)
    );

    initial forever #5 clk_sys = ~clk_sys;

    typedef struct {
        int         cyc;
        bit         c_col, c_sync, c_stat;
        logic [4:0] r, g, b;
        logic       hs, vs, hd, vd, lk;
    } exp_t;

    exp_t sb[$];
    exp_t me;
    int   cyc_cnt = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   h = 0, v = 0, fr = 0;
    bit   hs_inv = 0, vs_inv = 0, f_exp = 0, exp_hd = 0, exp_vd = 0;

    initial forever begin
        @(posedge clk_sys);
        cyc_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc_cnt, act, req);
        end
    endtask

    function automatic logic [4:0] exp_chan(input int c, input bit thr, input bit den);
        int o;
        o = c / 2;
        if (den && (c % 2 == 1) && thr) o = o + 1;
        if (o > 31) o = 31;
        return 5'(o);
    endfunction

    // One clock of stimulus: drive inputs from (h,v), queue the expected output, advance.
    task automatic step(input bit rst, input bit ccol, input bit cstat, input bit elk);
        exp_t e;
        bit hs_a, vs_a, xb, yb, thr;
        hs_a  = (h < HSW);
        vs_a  = (v < VSW);
        reset = rst;
        hs_in = hs_inv ? hs_a : !hs_a;
        vs_in = vs_inv ? vs_a : !vs_a;
        xb    = (h % 2 == 0);
        yb    = (v % 2 == 1);
        thr   = xb ^ yb ^ (f_exp & temporal_en);
        e.cyc = cyc_cnt + 1;
        e.c_col = ccol; e.c_sync = ccol; e.c_stat = cstat;
        if (rst) begin
            e.r = 0; e.g = 0; e.b = 0;
            e.hs = !hs_pol_out; e.vs = !vs_pol_out;
            e.hd = 0; e.vd = 0; e.lk = 0;
            f_exp = 0;
        end else begin
            e.r  = (hs_a || vs_a) ? 5'd0 : exp_chan(int'(r_in), thr, dither_en);
            e.g  = (hs_a || vs_a) ? 5'd0 : exp_chan(int'(g_in), thr, dither_en);
            e.b  = (hs_a || vs_a) ? 5'd0 : exp_chan(int'(b_in), thr, dither_en);
            e.hs = hs_pol_out ? hs_a : !hs_a;
            e.vs = vs_pol_out ? vs_a : !vs_a;
            e.hd = exp_hd; e.vd = exp_vd; e.lk = elk;
            if (h == 0 && v == 0 && temporal_en) f_exp = !f_exp;
        end
        sb.push_back(e);
        h++;
        if (h == L) begin
            h = 0; v++;
            if (v == NL) begin v = 0; fr++; end
        end
        @(posedge clk_sys);
        #1;
    endtask

    // Monitor: compare each queued expectation against the output on its cycle.
    initial forever begin
        @(negedge clk_sys);
        while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
            me = sb.pop_front();
            if (me.cyc != cyc_cnt) begin
                chk("sb_tag", me.cyc, cyc_cnt);
            end else begin
                if (me.c_col)  chk("colour", {VGA_R, VGA_G, VGA_B}, {me.r, me.g, me.b});
                if (me.c_sync) chk("sync", {VGA_HS, VGA_VS}, {me.hs, me.vs});
                if (me.c_stat) chk("status", {hs_pol_det, vs_pol_det, locked}, {me.hd, me.vd, me.lk});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cyc=%0d", cyc_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int  k;
        bit  seen;
        pix_ce = 1; r_in = 6'd33; g_in = 6'd63; b_in = 6'd1;
        dither_en = 1; temporal_en = 0; hs_pol_out = 0; vs_pol_out = 0;
        hs_in = 1; vs_in = 1; reset = 1;

        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        h = 0; v = 0; fr = 0;

        // Active-low stream, checkerboard dither; lock appears one clk after the 2nd VS measurement.
        while (fr < 4) step(0, 1, 1, (fr > 2) || (fr == 2 && (v > 2 || (v == 2 && h >= 1))));
        dither_en = 0;
        while (fr < 5) step(0, 1, 1, 1);
        dither_en = 1; temporal_en = 1;
        while (fr < 8) step(0, 1, 1, 1);
        temporal_en = 0;
        while (fr < 9) step(0, 1, 1, 1);

        // Flip HS polarity mid-frame.
        while (!(v == 5 && h == 20)) step(0, 1, 1, 1);
        hs_inv = 1;
        seen = 0; k = 0;
        while (!seen && k < 6 * L) begin
            step(0, 0, 0, 0);
            k++;
            if (hs_pol_det === 1'b1) seen = 1;
        end
        chk("hs_det_flip", seen, 1);
        if (seen) begin
            chk("lock_hold", locked, 1);
            step(0, 0, 0, 0);
            chk("lock_drop", locked, 0);
            k = 0;
            while (locked !== 1'b1 && k < 6 * L) begin
                step(0, 0, 0, 0);
                k++;
            end
            chk("relock_cycles", k, 2 * L);
        end
        chk("hs_det_new", {hs_pol_det, vs_pol_det}, 2'b10);

        // Flip VS polarity at a frame start; wait for the drop and the re-lock.
        while (!(v == 0 && h == 0)) step(0, 0, 0, 0);
        vs_inv = 1;
        k = 0;
        while (locked !== 1'b0 && k < 4 * NL * L) begin step(0, 0, 0, 0); k++; end
        chk("vs_lock_drop", locked, 0);
        k = 0;
        while (locked !== 1'b1 && k < 4 * NL * L) begin step(0, 0, 0, 0); k++; end
        chk("vs_relock", {hs_pol_det, vs_pol_det, locked}, 3'b111);

        // Active-high in, active-high out: output follows input delayed by one clock.
        hs_pol_out = 1; vs_pol_out = 1;
        exp_hd = 1; exp_vd = 1;
        r_in = 6'd33; g_in = 6'd62; b_in = 6'd1;
        while (!(v == 0 && h == 0)) step(0, 0, 0, 1);
        k = fr;
        while (fr == k) step(0, 1, 1, 1);

        // One-clock reset mid-line; detection needs a fresh low and high phase afterwards.
        while (!(v == 4 && h == 20)) step(0, 1, 1, 1);
        exp_hd = 0; exp_vd = 0;
        step(1, 1, 1, 0);
        while (!(v == 6 && h == 0)) step(0, 0, 1, 0);
        exp_hd = 1;
        step(0, 0, 1, 0);

        @(negedge clk_sys);
        #1;
        chk("sb_drain", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
